// File: rtl/pia_dsp_if.sv
// CPU bus plus terminal handshake for the PIA display port.
// master = CPU/terminal side, slave = pia_dsp.
interface pia_dsp_if;
  logic [15:0] Address_Bus;
  logic        WE;
  logic [7:0]  Data_In;
  logic [7:0]  Data_Out;
  logic        dsp_req;
  logic        dsp_ack;
  logic [6:0]  dsp_data;

  modport master (
    output Address_Bus, WE, Data_In, dsp_ack,
    input  Data_Out, dsp_req, dsp_data
  );

  modport slave (
    input  Address_Bus, WE, Data_In, dsp_ack,
    output Data_Out, dsp_req, dsp_data
  );
endinterface

// File: rtl/pia_dsp.sv
// Apple-1 PIA display port (DSP/DSPCR): forwards CPU-written ASCII to the terminal
// over a 4-phase req/ack handshake. Define DSP_FIFO_EN to buffer FIFO_DEPTH characters.
module pia_dsp #(
  parameter logic [15:0] DSP_ADDR   = 16'hD012,
  parameter logic [15:0] DSPCR_ADDR = 16'hD013,
  parameter int          FIFO_DEPTH = 4
) (
  input logic       clk,
  input logic       reset,
  pia_dsp_if.slave  bus
);

  typedef enum logic [2:0] {
    sIdle = 3'b001,
    sReq  = 3'b010,
    sDone = 3'b100
  } state_t;

  state_t      state;
  logic [7:0]  dspcr;
  logic [7:0]  ddr;
  logic [6:0]  dsp_char;
  logic        busy;
  logic        dsp_req;
  logic [6:0]  dsp_data;
  logic        start;
  logic [6:0]  start_data;

  logic dsp_wr, cr_wr, char_wr;
  assign dsp_wr  = bus.WE && (bus.Address_Bus == DSP_ADDR);
  assign cr_wr   = bus.WE && (bus.Address_Bus == DSPCR_ADDR);
  assign char_wr = dsp_wr && dspcr[2];

  // DDR is write-only here; it only exists so the WozMon init write lands somewhere.
  logic unused_ddr;
  assign unused_ddr = ^ddr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dspcr <= 8'h00;
      ddr   <= 8'h00;
    end else begin
      if (cr_wr)                ddr   <= ddr;
      if (cr_wr)                dspcr <= bus.Data_In;
      if (dsp_wr && !dspcr[2])  ddr   <= bus.Data_In;
    end
  end

`ifdef DSP_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  assign busy       = (count == (AW+1)'(FIFO_DEPTH));
  assign push       = char_wr && !busy;
  assign pop        = (state == sIdle) && (count != '0);
  assign start      = pop;
  assign start_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.Data_In[6:0];
  end

  // Power-of-2 depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dsp_char <= 7'h00;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        dsp_char <= bus.Data_In[6:0];
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;

  logic accept, release_busy;
  // Busy is only ever clear in sIdle, so the state term just guards illegal states.
  assign accept       = char_wr && !busy && (state == sIdle);
  assign release_busy = ((state == sDone) && !bus.dsp_ack) ||
                        !(state inside {sIdle, sReq, sDone});
  assign start        = accept;
  assign start_data   = bus.Data_In[6:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      dsp_char <= 7'h00;
    end else if (accept) begin
      busy     <= 1'b1;
      dsp_char <= bus.Data_In[6:0];
    end else if (release_busy) begin
      busy     <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= sIdle;
      dsp_req  <= 1'b0;
      dsp_data <= 7'h00;
    end else begin
      case (state)
        sIdle: if (start) begin
          dsp_data <= start_data;
          dsp_req  <= 1'b1;
          state    <= sReq;
        end
        sReq: if (bus.dsp_ack) begin
          dsp_req <= 1'b0;
          state   <= sDone;
        end
        sDone: if (!bus.dsp_ack) state <= sIdle;
        default: begin
          dsp_req <= 1'b0;
          state   <= sIdle;
        end
      endcase
    end
  end

  assign bus.dsp_req  = dsp_req;
  assign bus.dsp_data = dsp_data;
  assign bus.Data_Out = (bus.Address_Bus == DSPCR_ADDR) ? dspcr : {busy, dsp_char};

endmodule
